tb_loopback_checker: RTL and testbench

Simulation-side checker that sits directly downstream of the transceiver under test in the loop-back bench. It receives the 8-bit pattern the pattern generator drives into the transmitter (`i_ref`) and the 8-bit word recovered on the receiver's 5V-TTL outputs (`i_rx`). It searches for the link latency, locks onto it, and then counts hard errors and ±1-cycle jitter slips. The block is synthesizable RTL, so the same checker can also run on hardware for a self-test build.

---
 rtl/tb_loopback_checker.sv | 176 +++++++++++++++++
 tb/tb_tb_loopback_checker.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tb_loopback_checker.sv
// Loop-back link checker: searches for the ref->rx latency, locks onto it,
// then counts hard errors and +/-1 cycle jitter slips on the recovered word.
module tb_loopback_checker #(
  parameter int DATA_W   = 8,
  parameter int MAX_LAT  = 64,
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 4
) (
  input  logic              i_clk,
  input  logic              i_res,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_ref,
  input  logic [DATA_W-1:0] i_rx,
  output logic              o_locked,
  output logic [6:0]        o_latency,
  output logic [15:0]       o_err_cnt,
  output logic [15:0]       o_jit_cnt,
  output logic [31:0]       o_cmp_cnt,
  output logic              o_err_pulse,
  output logic [7:0]        o_sweeps
);

  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int LOSS_W = $clog2(LOSS_CNT + 1);
  localparam logic [6:0] LAT_LAST = 7'(MAX_LAT - 1);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [6:0]         lat_q, lat_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               edge_q, edge_d;
  logic [LOSS_W-1:0]  loss_q, loss_d;
  logic [15:0]        err_cnt_q, err_cnt_d;
  logic [15:0]        jit_cnt_q, jit_cnt_d;
  logic [31:0]        cmp_cnt_q, cmp_cnt_d;
  logic [7:0]         sweeps_q, sweeps_d;
  logic               err_pulse_q, err_pulse_d;
  logic               locked_q, locked_d;
  logic [DATA_W-1:0]  dly_q [MAX_LAT];
  logic [DATA_W-1:0]  dly_d [MAX_LAT];

  logic [DATA_W-1:0]  tap [MAX_LAT+1];
  logic [6:0]         lat_p1, lat_m1, lat_adv;
  logic [DATA_W-1:0]  tap_l, tap_p1, tap_m1;
  logic               is_match, is_slip, ref_edge, lat_wrap;
  logic [RUN_W-1:0]   run_inc;
  logic [LOSS_W-1:0]  loss_inc;
  logic [7:0]         sweeps_inc;

  // tap(0) is the live reference; tap(k) is the reference k cycles old
  always_comb begin
    tap[0] = i_ref;
    for (int k = 1; k <= MAX_LAT; k++) tap[k] = dly_q[k-1];
    dly_d[0] = i_ref;
    for (int k = 1; k < MAX_LAT; k++) dly_d[k] = dly_q[k-1];
  end

  always_comb begin
    lat_p1     = lat_q + 7'd1;
    lat_m1     = lat_q - 7'd1;
    lat_wrap   = (lat_q == LAT_LAST);
    lat_adv    = lat_wrap ? 7'd0 : lat_p1;
    tap_l      = tap[lat_q];
    tap_p1     = tap[lat_p1];
    tap_m1     = (lat_q != 7'd0) ? tap[lat_m1] : '0;
    is_match   = (i_rx == tap_l);
    is_slip    = !is_match && (((lat_q != 7'd0) && (i_rx == tap_m1)) || (i_rx == tap_p1));
    ref_edge   = (tap_l != tap_p1);
    run_inc    = (run_q == RUN_W'(LOCK_CNT)) ? run_q : run_q + RUN_W'(1);
    loss_inc   = loss_q + LOSS_W'(1);
    sweeps_inc = (lat_wrap && sweeps_q != 8'hFF) ? sweeps_q + 8'd1 : sweeps_q;
  end

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    run_d       = run_q;
    edge_d      = edge_q;
    loss_d      = loss_q;
    err_cnt_d   = err_cnt_q;
    jit_cnt_d   = jit_cnt_q;
    cmp_cnt_d   = cmp_cnt_q;
    sweeps_d    = sweeps_q;
    err_pulse_d = 1'b0;
    if (i_en) begin
      case (state_q)
        SEARCH: begin
          if (is_match) begin
            state_d = ACQUIRE;
            run_d   = RUN_W'(1);
            edge_d  = 1'b0;
          end else begin
            lat_d    = lat_adv;
            sweeps_d = sweeps_inc;
          end
        end
        ACQUIRE: begin
          if (is_match) begin
            run_d  = run_inc;
            edge_d = edge_q | ref_edge;
            // a constant reference matches every latency, so demand a change
            if (run_inc == RUN_W'(LOCK_CNT) && (edge_q || ref_edge)) begin
              state_d = LOCKED;
              loss_d  = '0;
            end
          end else begin
            state_d  = SEARCH;
            lat_d    = lat_adv;
            sweeps_d = sweeps_inc;
          end
        end
        LOCKED: begin
          cmp_cnt_d = cmp_cnt_q + 32'd1;
          if (is_match) begin
            loss_d = '0;
          end else if (is_slip) begin
            if (jit_cnt_q != 16'hFFFF) jit_cnt_d = jit_cnt_q + 16'd1;
            loss_d = '0;
          end else begin
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            err_pulse_d = 1'b1;
            // lost lock keeps L so the same latency is re-verified first
            if (loss_inc == LOSS_W'(LOSS_CNT)) begin
              state_d = SEARCH;
              loss_d  = '0;
            end else begin
              loss_d = loss_inc;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      state_q     <= SEARCH;
      lat_q       <= '0;
      run_q       <= '0;
      edge_q      <= 1'b0;
      loss_q      <= '0;
      err_cnt_q   <= '0;
      jit_cnt_q   <= '0;
      cmp_cnt_q   <= '0;
      sweeps_q    <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
      for (int k = 0; k < MAX_LAT; k++) dly_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      run_q       <= run_d;
      edge_q      <= edge_d;
      loss_q      <= loss_d;
      err_cnt_q   <= err_cnt_d;
      jit_cnt_q   <= jit_cnt_d;
      cmp_cnt_q   <= cmp_cnt_d;
      sweeps_q    <= sweeps_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
      for (int k = 0; k < MAX_LAT; k++) dly_q[k] <= dly_d[k];
    end
  end

  assign o_locked    = locked_q;
  assign o_latency   = lat_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_jit_cnt   = jit_cnt_q;
  assign o_cmp_cnt   = cmp_cnt_q;
  assign o_err_pulse = err_pulse_q;
  assign o_sweeps    = sweeps_q;

endmodule

// File: tb/tb_tb_loopback_checker.sv
// Directed bench for tb_loopback_checker: error pulses and lock events are
// checked by a scoreboard monitor, everything else by directed comparisons.
module tb_tb_loopback_checker;

  logic        clk = 1'b0;
  logic        i_res, i_en;
  logic [7:0]  i_ref, i_rx;
  logic        o_locked, o_err_pulse;
  logic [6:0]  o_latency;
  logic [15:0] o_err_cnt, o_jit_cnt;
  logic [31:0] o_cmp_cnt;
  logic [7:0]  o_sweeps;

  int checks = 0;
  int failures = 0;
  int pulse_count = 0;
  logic locked_prev = 1'b0;
  logic [7:0] hist [1:127];
  logic [7:0] pat;
  logic [7:0] exp_err_q [$];
  logic [6:0] exp_lock_q [$];

  always #8 clk = ~clk;

  tb_loopback_checker dut (
    .i_clk(clk), .i_res(i_res), .i_en(i_en), .i_ref(i_ref), .i_rx(i_rx),
    .o_locked(o_locked), .o_latency(o_latency), .o_err_cnt(o_err_cnt),
    .o_jit_cnt(o_jit_cnt), .o_cmp_cnt(o_cmp_cnt), .o_err_pulse(o_err_pulse),
    .o_sweeps(o_sweeps)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  // one clock: drive at negedge, return at the following negedge
  task automatic apply_stimulus(input logic en, input logic rst, input logic [7:0] ref_v, input logic [7:0] rx_v);
    i_en  = en;
    i_res = rst;
    i_ref = ref_v;
    i_rx  = rx_v;
    @(posedge clk);
    if (rst) begin
      for (int k = 1; k < 128; k++) hist[k] = 8'h00;
    end else begin
      for (int k = 127; k > 1; k--) hist[k] = hist[k-1];
      hist[1] = ref_v;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    apply_stimulus(1'b1, 1'b1, 8'h00, 8'h00);
    pat = 8'h00;
  endtask

  task automatic step_delay(input int d);
    pat++;
    apply_stimulus(1'b1, 1'b0, pat, (d == 0) ? pat : hist[d]);
  endtask

  task automatic corrupt_delay(input int d);
    pat++;
    apply_stimulus(1'b1, 1'b0, pat, hist[d] ^ 8'hFF);
  endtask

  task automatic wait_lock(input int d, input int budget, output int used);
    used = 0;
    for (int n = 1; n <= budget; n++) begin
      step_delay(d);
      used = n;
      if (o_locked) break;
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (o_err_pulse) begin
      pulse_count++;
      if (exp_err_q.size() == 0) check_output("unexpected_err_pulse", 32'd1, 32'd0);
      else check_output("err_cnt_at_pulse", 32'(o_err_cnt), 32'(exp_err_q.pop_front()));
    end
    if (o_locked && !locked_prev) begin
      if (exp_lock_q.size() == 0) check_output("unexpected_lock", 32'd1, 32'd0);
      else check_output("latency_at_lock", 32'(o_latency), 32'(exp_lock_q.pop_front()));
    end
    locked_prev <= o_locked;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int used;
    int base;
    logic ok;
    i_en = 1'b1; i_res = 1'b1; i_ref = 8'h00; i_rx = 8'h00; pat = 8'h00;
    for (int k = 1; k < 128; k++) hist[k] = 8'h00;
    @(negedge clk);

    do_reset();
    check_output("rst_locked", 32'(o_locked), 0);
    check_output("rst_latency", 32'(o_latency), 0);
    check_output("rst_sweeps", 32'(o_sweeps), 0);

    // fixed latency 5
    exp_lock_q.push_back(7'd5);
    wait_lock(5, 23, used);
    check_output("s1_locked", 32'(o_locked), 1);
    check_output("s1_latency", 32'(o_latency), 5);
    check_output("s1_err", 32'(o_err_cnt), 0);
    check_output("s1_jit", 32'(o_jit_cnt), 0);
    for (int n = 0; n < 10; n++) step_delay(5);
    check_output("s1_cmp_cnt", o_cmp_cnt, 10);

    // jitter slip at L=12
    do_reset();
    exp_lock_q.push_back(7'd12);
    wait_lock(12, 40, used);
    check_output("s2_locked", 32'(o_locked), 1);
    pat++;
    apply_stimulus(1'b1, 1'b0, pat, hist[13]);
    check_output("s2_jit", 32'(o_jit_cnt), 1);
    check_output("s2_err", 32'(o_err_cnt), 0);
    for (int n = 0; n < 5; n++) step_delay(12);
    check_output("s2_lock_held", 32'(o_locked), 1);

    // error bursts at L=3
    do_reset();
    exp_lock_q.push_back(7'd3);
    wait_lock(3, 30, used);
    check_output("s3_locked", 32'(o_locked), 1);
    base = pulse_count;
    for (int i = 1; i <= 3; i++) begin
      exp_err_q.push_back(8'(i));
      corrupt_delay(3);
    end
    step_delay(3);
    check_output("s3_err3", 32'(o_err_cnt), 3);
    check_output("s3_pulses3", 32'(pulse_count - base), 3);
    check_output("s3_lock_held", 32'(o_locked), 1);
    for (int i = 4; i <= 7; i++) begin
      exp_err_q.push_back(8'(i));
      corrupt_delay(3);
    end
    check_output("s3_lock_lost", 32'(o_locked), 0);
    check_output("s3_err7", 32'(o_err_cnt), 7);
    exp_lock_q.push_back(7'd3);
    ok = 1'b1;
    used = 0;
    for (int n = 1; n <= 20; n++) begin
      step_delay(3);
      used = n;
      if (o_latency != 7'd3) ok = 1'b0;
      if (o_locked) break;
    end
    check_output("s3_relock", 32'(o_locked), 1);
    check_output("s3_relock_fast", 32'(used <= 16), 1);
    check_output("s3_latency_held", 32'(ok), 1);
    check_output("s3_err_kept", 32'(o_err_cnt), 7);

    // static data never locks
    do_reset();
    for (int n = 0; n < 200; n++) apply_stimulus(1'b1, 1'b0, 8'h00, 8'h00);
    check_output("s4_static_unlocked", 32'(o_locked), 0);
    check_output("s4_static_latency", 32'(o_latency), 0);
    exp_lock_q.push_back(7'd0);
    wait_lock(0, 5, used);
    check_output("s4_count_locks", 32'(o_locked), 1);

    // uncorrelated rx: candidate sweeps and wraps
    do_reset();
    ok = 1'b1;
    for (int n = 1; n <= 130; n++) begin
      pat++;
      apply_stimulus(1'b1, 1'b0, {2'b00, pat[5:0]}, 8'h55);
      if (o_latency != 7'(n % 64)) ok = 1'b0;
      if (n == 64) begin
        check_output("s5_sweeps_at_64", 32'(o_sweeps), 1);
        check_output("s5_latency_at_64", 32'(o_latency), 0);
      end
    end
    check_output("s5_latency_sequence", 32'(ok), 1);
    check_output("s5_sweeps", 32'(o_sweeps), 2);
    check_output("s5_latency_end", 32'(o_latency), 2);
    check_output("s5_unlocked", 32'(o_locked), 0);

    // enable freeze mid-ACQUIRE, then reset while locked
    do_reset();
    for (int n = 0; n < 10; n++) step_delay(5);
    check_output("s6_acq_latency", 32'(o_latency), 5);
    check_output("s6_acq_unlocked", 32'(o_locked), 0);
    ok = 1'b1;
    for (int n = 0; n < 10; n++) begin
      pat++;
      apply_stimulus(1'b0, 1'b0, pat, 8'h55);
      if (o_latency != 7'd5 || o_locked || o_err_cnt != 0 || o_jit_cnt != 0 ||
          o_cmp_cnt != 0 || o_sweeps != 0 || o_err_pulse) ok = 1'b0;
    end
    check_output("s6_frozen", 32'(ok), 1);
    exp_lock_q.push_back(7'd5);
    wait_lock(5, 11, used);
    check_output("s6_run_held_lock", 32'(o_locked), 1);
    step_delay(5);
    step_delay(5);
    exp_err_q.push_back(8'd1);
    corrupt_delay(5);
    pat++;
    apply_stimulus(1'b1, 1'b0, pat, hist[6]);
    check_output("s6_err", 32'(o_err_cnt), 1);
    check_output("s6_jit", 32'(o_jit_cnt), 1);
    check_output("s6_cmp", o_cmp_cnt, 4);
    check_output("s6_locked_pre_rst", 32'(o_locked), 1);
    apply_stimulus(1'b1, 1'b1, pat, pat);
    check_output("s6_rst_locked", 32'(o_locked), 0);
    check_output("s6_rst_latency", 32'(o_latency), 0);
    check_output("s6_rst_err", 32'(o_err_cnt), 0);
    check_output("s6_rst_jit", 32'(o_jit_cnt), 0);
    check_output("s6_rst_cmp", o_cmp_cnt, 0);
    check_output("s6_rst_pulse", 32'(o_err_pulse), 0);
    check_output("s6_rst_sweeps", 32'(o_sweeps), 0);

    @(negedge clk);
    check_output("err_queue_drained", 32'(exp_err_q.size()), 0);
    check_output("lock_queue_drained", 32'(exp_lock_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
